uart_word_rx: RTL and testbench
===============================

Name: uart_word_rx

Overview:
- Parametrised successor to the current UART receive driver: internal baud-tick generator, 16x-oversampled serial receiver with runtime parity mode and error detection, and a byte-to-word assembler feeding a word FIFO.
- Delivers complete WORD_BYTES-byte words (for example, 64-byte SHA-1 message blocks) to the hashing core.
- Adds capabilities the current driver lacks: parity and framing checks, overrun reporting, and a synthesizable in-block FIFO (no vendor FIFO IP).

Parameters:
- DBIT, 8, data bits per UART character.
- WORD_BYTES, 64, characters per assembled word; word width W = DBIT*WORD_BYTES.
- SB_TICK, 16, oversample ticks per stop bit (16/24/32 for 1/1.5/2 stop bits).
- FIFO_DEPTH, 4, word FIFO depth; must be a power of 2 and at least 2.
- DIV_BITS, 11, width of the baud divisor.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- rx, input, 1, serial line; asynchronous to clk; idle high.
- timer_final_value, input, DIV_BITS, baud divisor; tick period = value+1 clocks.
- parity_mode, input, 2, 00 = none, 01 = even, 10 = odd, 11 = none.
- rd_uart, input, 1, pop the FIFO head.
- err_clr, input, 1, clear the sticky error flags.
- r_data, output, W, FIFO head word (show-ahead).
- rx_empty, output, 1, FIFO empty.
- rx_full, output, 1, FIFO full.
- level, output, clog2(FIFO_DEPTH)+1, number of words held.
- frame_err, output, 1, sticky: stop bit sampled low.
- parity_err, output, 1, sticky: parity mismatch.
- overrun, output, 1, sticky: completed word dropped because the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous):
  - All state clears: counters, FSM = IDLE, FIFO pointers, partial word, sync flops set to 1.
  - Outputs: rx_empty = 1, rx_full = 0, level = 0, r_data = 0, all error flags = 0.
  - Reset mid-character or mid-word discards the partial data.
- Tick generator:
  - Counter runs 0..timer_final_value. tick is high for exactly one clock when count == timer_final_value; the counter then returns to 0.
  - timer_final_value = 0 gives a tick every clock.
  - A divisor change takes effect at the next wrap or whenever count > new value (counter restarts at 0).
- rx passes through a 2-FF synchroniser before use; the FSM sees rx_s.
- Receiver FSM, advancing on ticks only:
  - IDLE: on rx_s = 0, go to START and clear the tick count.
  - START: at tick 7, if rx_s = 0 clear the count and go to DATA; else return to IDLE (glitch rejected, no error).
  - DATA: sample rx_s every 16th tick, LSB first, DBIT bits. Then go to PARITY if parity_mode is 01 or 10, else STOP.
  - PARITY: sample at the 16th tick. Error if (XOR of data bits XOR parity bit) != (parity_mode == 10).
  - STOP: sample at tick SB_TICK-1; rx_s = 0 is a framing error. Then return to IDLE.
- Character completion (one clock after the final stop tick):
  - Good character: shifted into the word register MSB-first (first received byte lands in r_data[W-1 -: DBIT]); byte counter increments.
  - Bad character: sets the relevant sticky flag(s). The character and the whole partial word are discarded; the byte counter returns to 0.
- Word completion: when the byte counter reaches WORD_BYTES, the word is pushed to the FIFO in the same clock and the byte counter wraps to 0. rx_empty falls on the following clock.
- FIFO:
  - Push when not full. If full and rd_uart is high in the same clock, pop and push both occur and level is unchanged.
  - If full with no pop, the word is dropped and overrun is set.
  - rd_uart while empty is ignored.
  - r_data updates the clock after a pop; it is don't-care only while rx_empty = 1 and holds 0 after reset.
  - Pointers are clog2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; level = wr_ptr - rd_ptr.
- Sticky flags: err_clr clears them. A new error in the same clock as err_clr wins (flag stays set).

Test Plan:
- Setup: WORD_BYTES=4, FIFO_DEPTH=2, timer_final_value=3, parity_mode=00. Send 0xDE,0xAD,0xBE,0xEF -> rx_empty falls once, r_data=0xDEADBEEF, level=1; pulse rd_uart -> rx_empty=1.
- parity_mode=01; send 0x01 with parity bit 0 -> parity_err=1 and the partial word is dropped; then 4 good bytes 0x11223344 -> r_data=0x11223344; err_clr -> parity_err=0.
- Send 3 good bytes, then 0x55 with stop bit low -> frame_err=1, FIFO unchanged; the next 4 bytes form a fresh word.
- Send 3 words without reading -> level=2, rx_full=1, overrun=1, and the head is still the first word. Repeat with rd_uart pulsed coincident with the third push -> overrun=0, level=2.
- 1-tick low glitch on rx, then rst pulsed low mid-byte -> no byte accepted; all outputs return to reset values immediately (asynchronously).
- timer_final_value=0 and SB_TICK=32, full word received -> correct data; stop check occurs at tick 31.

Source files
------------

// File: rtl/uart_word_rx_if.sv
// Word delivery interface of uart_word_rx.
//   master : receiver side  - drives r_data, rx_empty, rx_full, level; reads rd_uart
//   slave  : consumer side  - drives rd_uart; reads r_data, rx_empty, rx_full, level
// W  = word width (DBIT*WORD_BYTES), LW = level width (clog2(FIFO_DEPTH)+1).
interface uart_word_rx_if #(
  parameter int unsigned W  = 512,
  parameter int unsigned LW = 3
);
  logic          rd_uart;
  logic [W-1:0]  r_data;
  logic          rx_empty;
  logic          rx_full;
  logic [LW-1:0] level;

  modport master (input rd_uart, output r_data, rx_empty, rx_full, level);
  modport slave  (output rd_uart, input r_data, rx_empty, rx_full, level);
endinterface

// File: rtl/uart_word_rx.sv
// UART word receiver: baud-tick generator, 16x-oversampled receiver with
// runtime parity and error detection, byte-to-word assembler and word FIFO.
// Ports:
//   clk, rst (async, active low)     - clock / reset
//   rx                               - serial line (async, idle high)
//   timer_final_value                - baud divisor, tick every value+1 clocks
//   parity_mode                      - 00/11 none, 01 even, 10 odd
//   err_clr                          - clears sticky error flags
//   bus (master)                     - rd_uart, r_data, rx_empty, rx_full, level
//   frame_err, parity_err, overrun   - sticky error flags
module uart_word_rx #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned WORD_BYTES = 64,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_BITS   = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic [DIV_BITS-1:0] timer_final_value,
  input  logic [1:0]          parity_mode,
  input  logic                err_clr,
  uart_word_rx_if.master      bus,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun
);
  localparam int unsigned W  = DBIT * WORD_BYTES;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int unsigned NW = $clog2(DBIT + 1);
  localparam int unsigned BW = $clog2(WORD_BYTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- tick generator ----------------
  logic [DIV_BITS-1:0] cnt_q;
  logic                tick;
  assign tick = (cnt_q == timer_final_value);

  // >= also restarts the count when the divisor drops below it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           cnt_q <= '0;
    else if (cnt_q >= timer_final_value) cnt_q <= '0;
    else                                cnt_q <= cnt_q + 1'b1;
  end

  // ---------------- synchroniser ----------------
  logic rx_meta_q, rx_s_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------- receiver FSM ----------------
  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            pbad_q, pbad_d;
  logic            fbad_q, fbad_d;
  logic            done_q, done_d;
  logic            par_en;
  assign par_en = (parity_mode == 2'b01) || (parity_mode == 2'b10);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      pbad_q  <= 1'b0;
      fbad_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      pbad_q  <= pbad_d;
      fbad_q  <= fbad_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    pbad_d  = pbad_q;
    fbad_d  = fbad_q;
    done_d  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            s_d     = '0;
          end
        end
        S_START: begin
          if (s_q == SW'(7)) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              s_d     = '0;
              n_d     = '0;
              pbad_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
        S_DATA: begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) state_d = par_en ? S_PARITY : S_STOP;
            else                      n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            pbad_d  = ((^b_q) ^ rx_s_q) != (parity_mode == 2'b10);
            state_d = S_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
        S_STOP: begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            fbad_d  = !rx_s_q;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- word assembler ----------------
  logic [W-1:0]  word_q, word_shift;
  logic [BW-1:0] bcnt_q;
  logic          char_bad, char_good, push_req;

  assign word_shift = {word_q[W-DBIT-1:0], b_q};
  assign char_bad   = done_q && (fbad_q || pbad_q);
  assign char_good  = done_q && !fbad_q && !pbad_q;
  assign push_req   = char_good && (bcnt_q == BW'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      bcnt_q <= '0;
    end else if (char_bad) begin
      word_q <= '0;
      bcnt_q <= '0;
    end else if (char_good) begin
      word_q <= word_shift;
      bcnt_q <= push_req ? '0 : bcnt_q + 1'b1;
    end
  end

  // ---------------- word FIFO ----------------
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          empty, full, pop, push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = bus.rd_uart && !empty;
  // a simultaneous pop frees the slot the push needs
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= word_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // head is forced to zero while empty so no unwritten memory is exposed
  assign bus.r_data   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign bus.rx_empty = empty;
  assign bus.rx_full  = full;
  assign bus.level    = wr_ptr_q - rd_ptr_q;

  // ---------------- sticky flags ----------------
  logic ferr_q, perr_q, ovr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= (ferr_q && !err_clr) || (done_q && fbad_q);
      perr_q <= (perr_q && !err_clr) || (done_q && pbad_q);
      ovr_q  <= (ovr_q  && !err_clr) || (push_req && full && !pop);
    end
  end

  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_word_rx.sv
module tb_uart_word_rx;
  logic        clk = 1'b0;
  logic        rst, rx, rx2, err_clr;
  logic [10:0] tfv, tfv2;
  logic [1:0]  pmode, pmode2;
  logic        frame_err, parity_err, overrun;
  logic        frame_err2, parity_err2, overrun2;
  int          tests = 0;
  int          fails = 0;

  uart_word_rx_if #(.W(32), .LW(2)) bus ();
  uart_word_rx_if #(.W(32), .LW(2)) bus2 ();

  uart_word_rx #(.DBIT(8), .WORD_BYTES(4), .SB_TICK(16), .FIFO_DEPTH(2), .DIV_BITS(11)) dut (
    .clk(clk), .rst(rst), .rx(rx), .timer_final_value(tfv), .parity_mode(pmode),
    .err_clr(err_clr), .bus(bus), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun));

  uart_word_rx #(.DBIT(8), .WORD_BYTES(4), .SB_TICK(32), .FIFO_DEPTH(2), .DIV_BITS(11)) dut32 (
    .clk(clk), .rst(rst), .rx(rx2), .timer_final_value(tfv2), .parity_mode(pmode2),
    .err_clr(err_clr), .bus(bus2), .frame_err(frame_err2), .parity_err(parity_err2),
    .overrun(overrun2));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  pm;
    logic [31:0] exp_data;
    logic [1:0]  exp_level;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit second, input logic v);
    if (second) rx2 = v;
    else        rx  = v;
  endtask

  // one character: start, 8 data LSB first, optional parity, then the stop
  // region as stop_hi high clocks, stop_lo low clocks, gap high clocks
  task automatic send_char(input bit second, input logic [7:0] d, input logic [1:0] pm,
                           input bit bad_par, input int stop_hi, input int stop_lo,
                           input int gap);
    int bc;
    bc = second ? 16 : 64;
    drive(second, 1'b0);
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(second, d[i]);
      repeat (bc) @(negedge clk);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      drive(second, (^d) ^ (pm == 2'b10) ^ bad_par);
      repeat (bc) @(negedge clk);
    end
    drive(second, 1'b1);
    repeat (stop_hi) @(negedge clk);
    if (stop_lo > 0) begin
      drive(second, 1'b0);
      repeat (stop_lo) @(negedge clk);
    end
    drive(second, 1'b1);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [31:0] w, input int nbytes, input logic [1:0] pm);
    for (int k = 0; k < nbytes; k++)
      send_char(1'b0, w[31-8*k -: 8], pm, 1'b0, 80, 0, 0);
  endtask

  task automatic pop();
    @(negedge clk) bus.rd_uart = 1'b1;
    @(negedge clk) bus.rd_uart = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  initial begin
    bit hit;
    vecs[0] = '{word: 32'hDEADBEEF, pm: 2'b00, exp_data: 32'hDEADBEEF, exp_level: 2'd1};
    vecs[1] = '{word: 32'hA5C3007F, pm: 2'b01, exp_data: 32'hA5C3007F, exp_level: 2'd1};
    vecs[2] = '{word: 32'h0081FF18, pm: 2'b10, exp_data: 32'h0081FF18, exp_level: 2'd1};
    vecs[3] = '{word: 32'h13579BDF, pm: 2'b11, exp_data: 32'h13579BDF, exp_level: 2'd1};

    rst = 1'b0; rx = 1'b1; rx2 = 1'b1; err_clr = 1'b0;
    tfv = 11'd3; tfv2 = 11'd0; pmode = 2'b00; pmode2 = 2'b00;
    bus.rd_uart = 1'b0; bus2.rd_uart = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_empty", bus.rx_empty, 1);
    check("reset_full", bus.rx_full, 0);
    check("reset_level", bus.level, 0);
    check("reset_rdata", bus.r_data, 0);
    check("reset_flags", {frame_err, parity_err, overrun}, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // table: one word per row under each parity mode
    for (int v = 0; v < 4; v++) begin
      pmode = vecs[v].pm;
      send_bytes(vecs[v].word, 3, vecs[v].pm);
      check("row_empty_partial", bus.rx_empty, 1);
      send_bytes({vecs[v].word[7:0], 24'h0}, 1, vecs[v].pm);
      check("row_rdata", bus.r_data, vecs[v].exp_data);
      check("row_level", bus.level, vecs[v].exp_level);
      check("row_empty", bus.rx_empty, 0);
      check("row_perr", parity_err, 0);
      pop();
      check("row_pop_empty", bus.rx_empty, 1);
    end

    // bad parity drops the partial word
    pmode = 2'b01;
    send_char(1'b0, 8'h99, 2'b01, 1'b0, 80, 0, 0);
    send_char(1'b0, 8'h01, 2'b01, 1'b1, 80, 0, 0);
    check("par_err_set", parity_err, 1);
    check("par_empty", bus.rx_empty, 1);
    send_bytes(32'h11223344, 4, 2'b01);
    check("par_word", bus.r_data, 32'h11223344);
    check("par_level", bus.level, 1);
    check("par_err_sticky", parity_err, 1);
    clear_errs();
    check("par_err_clr", parity_err, 0);
    pop();

    // bad stop bit drops the partial word
    pmode = 2'b00;
    send_bytes(32'hAABBCC00, 3, 2'b00);
    send_char(1'b0, 8'h55, 2'b00, 1'b0, 0, 48, 128);
    check("frm_err_set", frame_err, 1);
    check("frm_level", bus.level, 0);
    send_bytes(32'h01020304, 4, 2'b00);
    check("frm_word", bus.r_data, 32'h01020304);
    check("frm_parity_clean", parity_err, 0);
    clear_errs();
    check("frm_err_clr", frame_err, 0);
    pop();

    // overflow without reads
    send_bytes(32'h10000001, 4, 2'b00);
    send_bytes(32'h20000002, 4, 2'b00);
    check("ovr_full", bus.rx_full, 1);
    check("ovr_not_yet", overrun, 0);
    send_bytes(32'h30000003, 4, 2'b00);
    check("ovr_set", overrun, 1);
    check("ovr_level", bus.level, 2);
    check("ovr_head", bus.r_data, 32'h10000001);
    pop();
    check("ovr_second", bus.r_data, 32'h20000002);
    check("ovr_level1", bus.level, 1);
    pop();
    check("ovr_drained", bus.rx_empty, 1);
    clear_errs();
    check("ovr_clr", overrun, 0);

    // push coincident with pop while full
    send_bytes(32'h40000004, 4, 2'b00);
    send_bytes(32'h50000005, 4, 2'b00);
    send_bytes(32'h60000006, 3, 2'b00);
    hit = 1'b0;
    fork
      send_char(1'b0, 8'h06, 2'b00, 1'b0, 80, 0, 0);
      begin
        for (int c = 0; c < 1500 && !hit; c++) begin
          @(negedge clk);
          if (dut.done_q) begin
            hit = 1'b1;
            bus.rd_uart = 1'b1;
            @(negedge clk);
            bus.rd_uart = 1'b0;
          end
        end
      end
    join
    check("coin_seen", hit, 1);
    check("coin_overrun", overrun, 0);
    check("coin_level", bus.level, 2);
    check("coin_head", bus.r_data, 32'h50000005);

    // set a flag, then reset asynchronously in the middle of a byte
    pmode = 2'b01;
    send_char(1'b0, 8'h01, 2'b01, 1'b1, 80, 0, 0);
    check("pre_rst_perr", parity_err, 1);
    pmode = 2'b00;
    send_bytes(32'h77880000, 2, 2'b00);
    rx = 1'b0;
    repeat (64 + 3 * 64) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_empty", bus.rx_empty, 1);
    check("arst_full", bus.rx_full, 0);
    check("arst_level", bus.level, 0);
    check("arst_rdata", bus.r_data, 0);
    check("arst_flags", {frame_err, parity_err, overrun}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    // short low glitch must not start a character
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    send_bytes(32'hCAFEF00D, 4, 2'b00);
    check("post_rst_word", bus.r_data, 32'hCAFEF00D);
    check("post_rst_level", bus.level, 1);
    check("post_rst_flags", {frame_err, parity_err, overrun}, 0);
    pop();

    // divisor 0, two stop bits
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w2;
      w2 = 32'h5A0FF03C;
      send_char(1'b1, w2[31-8*k -: 8], 2'b00, 1'b0, 48, 0, 0);
    end
    check("sb32_word", bus2.r_data, 32'h5A0FF03C);
    check("sb32_level", bus2.level, 1);
    check("sb32_ferr_clean", frame_err2, 0);
    // only one stop bit high: the late stop sample sees the low line
    send_char(1'b1, 8'h77, 2'b00, 1'b0, 16, 12, 64);
    check("sb32_ferr_late", frame_err2, 1);
    check("sb32_level_kept", bus2.level, 1);
    check("sb16_ferr_untouched", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
